// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access modes, FSM states,
// lane geometry and the request bundle handed to the lane controller.
package data_mem_responder_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic MEM_MODE_WORD = 1'b0;
    localparam logic MEM_MODE_BYTE = 1'b1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_t;

    typedef struct packed {
        logic                   mem_write;
        logic                   mem_mode;
        logic [1:0]             lane_sel;
        logic [WORD_W-1:0]      data_in;
    } dmem_req_t;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] lane);
        return NUM_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/dmem_lane_ctl.sv
// Combinational byte-lane steering: byte enables and replicated write data for
// stores, lane extraction / zero-extension for loads, and misalignment detect.
module dmem_lane_ctl
    import data_mem_responder_pkg::*;
(
    input  logic                                req_write,
    input  logic                                req_mode,
    input  logic [1:0]                          req_lane,
    input  logic [WORD_W-1:0]                   req_data,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]    raw_word,
    output logic [NUM_LANES-1:0]                byte_en,
    output logic [NUM_LANES-1:0][LANE_W-1:0]    wr_data,
    output logic [WORD_W-1:0]                   rd_data,
    output logic                                misaligned
);

    dmem_req_t req;
    logic      is_word;

    assign req        = '{mem_write: req_write, mem_mode: req_mode,
                          lane_sel: req_lane, data_in: req_data};
    assign is_word    = (req.mem_mode == MEM_MODE_WORD);
    assign misaligned = is_word && (req.lane_sel != 2'd0);

    always_comb begin
        byte_en = '0;
        if (req.mem_write && !misaligned)
            byte_en = is_word ? '1 : lane_onehot(req.lane_sel);
    end

    // Byte stores replicate the low byte across all lanes; enables pick the lane.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign wr_data[g] = is_word ? req.data_in[g*LANE_W +: LANE_W]
                                    : req.data_in[LANE_W-1:0];
    end

    assign rd_data = is_word ? raw_word
                             : {{(WORD_W-LANE_W){1'b0}}, raw_word[req.lane_sel]};

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the core's D_MEM interface: power-on clear engine,
// byte-enabled word storage and registered read data / misaligned pulse.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  memMode,
    input  logic [WORD_WIDTH-1:0] dataIn,
    output logic [WORD_WIDTH-1:0] dataOut,
    output logic                  ready,
    output logic                  misaligned
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH];

    dmem_state_t                      state;
    logic [IDX_W-1:0]                 clr_cnt;

    logic [IDX_W-1:0]                 req_idx;
    logic [NUM_LANES-1:0][LANE_W-1:0] raw_word;
    logic [NUM_LANES-1:0]             lane_be;
    logic [NUM_LANES-1:0][LANE_W-1:0] lane_wdata;
    logic [WORD_W-1:0]                lane_rdata;
    logic                             lane_mis;

    logic [IDX_W-1:0]                 wr_idx;
    logic [NUM_LANES-1:0]             wr_be;
    logic [NUM_LANES-1:0][LANE_W-1:0] wr_word;

    logic                             unused_addr;

    // Upper address bits are dropped so accesses wrap modulo 4*DEPTH.
    assign req_idx     = addr[IDX_W+1:2];
    assign raw_word    = mem[req_idx];
    assign unused_addr = ^addr[ADDR_WIDTH-1:IDX_W+2];

    dmem_lane_ctl u_lane (
        .req_write  (memWrite),
        .req_mode   (memMode),
        .req_lane   (addr[1:0]),
        .req_data   (dataIn),
        .raw_word   (raw_word),
        .byte_en    (lane_be),
        .wr_data    (lane_wdata),
        .rd_data    (lane_rdata),
        .misaligned (lane_mis)
    );

    // Single write port shared by the clear engine and core stores.
    always_comb begin
        wr_idx  = req_idx;
        wr_be   = '0;
        wr_word = lane_wdata;
        if (rst_n) begin
            if (state == INIT) begin
                wr_idx  = clr_cnt;
                wr_be   = '1;
                wr_word = '0;
            end else begin
                wr_be   = lane_be;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_LANES; b++)
            if (wr_be[b]) mem[wr_idx][b] <= wr_word[b];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= (INIT_CLEAR != 0) ? INIT : RUN;
            clr_cnt    <= '0;
            dataOut    <= '0;
            ready      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    misaligned <= 1'b0;
                    clr_cnt    <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH-1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready      <= 1'b1;
                    misaligned <= (memRead || memWrite) && lane_mis;
                    // Reads sample the pre-write word, giving read-before-write.
                    if (memRead)
                        dataOut <= lane_mis ? '0 : lane_rdata;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (DEPTH=16) against a byte-array model.
module tb_data_mem_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        memRead, memWrite, memMode;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        ready, misaligned;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  m_bytes [4*DEPTH];
    int          m_clear_left;
    logic        m_ready;
    logic [31:0] m_dout;
    logic        m_mis;

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_WIDTH (32),
        .WORD_WIDTH (32),
        .DEPTH      (DEPTH),
        .INIT_CLEAR (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memMode    (memMode),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .ready      (ready),
        .misaligned (misaligned)
    );

    // Drive one request, clock it in, advance the model, settle 1ns past the edge.
    task automatic do_cycle(input logic r, input logic rd, input logic wr,
                            input logic mode, input logic [31:0] a, input logic [31:0] d);
        int w, ln;
        logic bad_al;
        logic [31:0] old;
        rst_n = r; memRead = rd; memWrite = wr; memMode = mode; addr = a; dataIn = d;
        @(posedge clk);
        if (!r) begin
            m_clear_left = DEPTH; m_ready = 0; m_dout = 0; m_mis = 0;
        end else if (m_clear_left > 0) begin
            w = DEPTH - m_clear_left;
            for (int k = 0; k < 4; k++) m_bytes[w*4+k] = 8'h00;
            m_clear_left--;
            m_mis = 0;
            if (m_clear_left == 0) m_ready = 1;
        end else begin
            m_ready = 1;
            w  = int'((a / 4) % DEPTH);
            ln = int'(a % 4);
            bad_al = (mode == 1'b0) && (ln != 0);
            m_mis  = (rd || wr) && bad_al;
            old = {m_bytes[w*4+3], m_bytes[w*4+2], m_bytes[w*4+1], m_bytes[w*4]};
            if (rd) m_dout = bad_al ? 32'h0 : (mode ? {24'h0, m_bytes[w*4+ln]} : old);
            if (wr && !bad_al) begin
                if (mode) m_bytes[w*4+ln] = d[7:0];
                else for (int k = 0; k < 4; k++) m_bytes[w*4+k] = d[8*k +: 8];
            end
        end
        #1;
    endtask

    task automatic idle(); do_cycle(1, 0, 0, 0, 32'h0, 32'h0); endtask

    task automatic test_reset();
        do_cycle(0, 0, 0, 0, 32'h0, 32'h0);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", dataOut); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis: got %b want 0", misaligned); end
        // requests during the clear must be ignored
        for (int i = 1; i <= DEPTH; i++) begin
            do_cycle(1, 1, 1, 0, $urandom_range(0, 63) & 32'hFC, $urandom);
            total++;
            if (ready !== (i == DEPTH) || dataOut !== 32'h0 || misaligned !== 1'b0) begin
                bad++;
                $display("FAIL init_cycle%0d: got ready=%b dout=%h mis=%b want ready=%b dout=0 mis=0",
                         i, ready, dataOut, misaligned, (i == DEPTH));
            end
        end
        do_cycle(1, 1, 0, 0, 32'h3C, 32'h0);
        total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL read_cleared: got %h want 0", dataOut); end
    endtask

    task automatic test_word();
        do_cycle(1, 0, 1, 0, 32'h10, 32'hDEADBEEF);
        do_cycle(1, 1, 0, 0, 32'h10, 32'h0);
        total++; if (dataOut !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd: got %h want deadbeef", dataOut); end
        idle(); idle();
        total++; if (dataOut !== 32'hDEADBEEF) begin bad++; $display("FAIL word_hold: got %h want deadbeef", dataOut); end
    endtask

    task automatic test_byte();
        do_cycle(1, 0, 1, 1, 32'h11, 32'h123456AA);
        do_cycle(1, 1, 0, 0, 32'h10, 32'h0);
        total++; if (dataOut !== 32'hDEADAAEF) begin bad++; $display("FAIL byte_wr: got %h want deadaaef", dataOut); end
        do_cycle(1, 1, 0, 1, 32'h13, 32'h0);
        total++; if (dataOut !== 32'h000000DE) begin bad++; $display("FAIL byte_rd: got %h want 000000de", dataOut); end
    endtask

    task automatic test_misaligned();
        do_cycle(1, 0, 1, 0, 32'h12, 32'h12345678);
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis_wr_pulse: got %b want 1", misaligned); end
        idle();
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_one_cycle: got %b want 0", misaligned); end
        do_cycle(1, 1, 0, 0, 32'h10, 32'h0);
        total++; if (dataOut !== 32'hDEADAAEF) begin bad++; $display("FAIL mis_wr_suppressed: got %h want deadaaef", dataOut); end
        do_cycle(1, 1, 0, 0, 32'h12, 32'h0);
        total++; if (dataOut !== 32'h0 || misaligned !== 1'b1) begin
            bad++; $display("FAIL mis_rd: got dout=%h mis=%b want dout=0 mis=1", dataOut, misaligned); end
    endtask

    task automatic test_wrap_rbw();
        do_cycle(1, 0, 1, 0, 32'h40, 32'hCAFEF00D);
        do_cycle(1, 1, 0, 0, 32'h00, 32'h0);
        total++; if (dataOut !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap: got %h want cafef00d", dataOut); end
        do_cycle(1, 1, 1, 0, 32'h00, 32'h1);
        total++; if (dataOut !== 32'hCAFEF00D) begin bad++; $display("FAIL rbw_old: got %h want cafef00d", dataOut); end
        do_cycle(1, 1, 0, 0, 32'h00, 32'h0);
        total++; if (dataOut !== 32'h1) begin bad++; $display("FAIL rbw_new: got %h want 00000001", dataOut); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            do_cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
            total++;
            if (dataOut !== m_dout || misaligned !== m_mis || ready !== m_ready) begin
                bad++;
                $display("FAIL rand%0d: got dout=%h mis=%b rdy=%b want dout=%h mis=%b rdy=%b",
                         i, dataOut, misaligned, ready, m_dout, m_mis, m_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        // reset while running
        do_cycle(1, 0, 1, 0, 32'h08, 32'h55AA55AA);
        do_cycle(0, 1, 1, 0, 32'h08, 32'h0);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL run_rst_ready: got %b want 0", ready); end
        n = 0;
        while (ready !== 1'b1 && n < 40) begin idle(); n++; end
        total++; if (n != DEPTH) begin bad++; $display("FAIL run_rst_clear_len: got %0d want %0d", n, DEPTH); end
        do_cycle(1, 1, 0, 0, 32'h08, 32'h0);
        total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL run_rst_data: got %h want 0", dataOut); end
        // reset while still clearing
        do_cycle(1, 0, 1, 0, 32'h3C, 32'hA5A5A5A5);
        do_cycle(0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) idle();
        do_cycle(0, 0, 0, 0, 32'h0, 32'h0);
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL init_rst_ready: got %b want 0", ready); end
        n = 0;
        while (ready !== 1'b1 && n < 40) begin idle(); n++; end
        total++; if (n != DEPTH) begin bad++; $display("FAIL init_rst_clear_len: got %0d want %0d", n, DEPTH); end
        do_cycle(1, 1, 0, 0, 32'h3C, 32'h0);
        total++; if (dataOut !== 32'h0 || dataOut !== m_dout) begin
            bad++; $display("FAIL init_rst_data: got %h want 0", dataOut); end
    endtask

    initial begin
        rst_n = 0; memRead = 0; memWrite = 0; memMode = 0; addr = '0; dataIn = '0;
        m_clear_left = DEPTH; m_ready = 0; m_dout = 0; m_mis = 0;
        for (int k = 0; k < 4*DEPTH; k++) m_bytes[k] = 8'h00;
        @(negedge clk);
        test_reset();
        test_word();
        test_byte();
        test_misaligned();
        test_wrap_rbw();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
